// File: rtl/desc_fetch_pkg.sv
// desc_fetch_pkg
// Shared definitions for the multi-channel descriptor ring fetcher:
//   fetch_state_t : fetch FSM states (IDLE, ARB, AR, RD, OUT)
//   BURST_INCR    : AXI INCR burst encoding
//   RESP_OKAY     : AXI OKAY response encoding
//   calc_arsize   : AXI arsize encoding for a given data-bus width in bits
package desc_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    AR,
    RD,
    OUT
  } fetch_state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic logic [2:0] calc_arsize(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Round-robin arbiter over NUM_CH request lines. The search starts at the
// channel after the last accepted grant; channel 0 has priority after reset.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   req        : per-channel request
//   accept     : the current grant is taken; advances the rotation pointer
//   gnt        : one-hot grant (combinational)
//   gnt_idx    : index of the granted channel
//   gnt_any    : some channel is granted
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              accept,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              gnt_any
);

  logic [CH_W-1:0] ptr;

  always_comb begin
    int              c;
    logic [CH_W-1:0] cidx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    c       = 0;
    cidx    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // Walk the channels starting at ptr, wrapping at NUM_CH.
      c = int'(ptr) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      cidx = CH_W'(c);
      if (!gnt_any && req[cidx]) begin
        gnt[cidx] = 1'b1;
        gnt_idx   = cidx;
        gnt_any   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept && gnt_any) begin
      ptr <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
    end
  end

endmodule

// File: rtl/desc_ring_fetcher_mc.sv
// desc_ring_fetcher_mc
// Multi-channel descriptor ring fetcher. Each of NUM_CH rings has a base,
// size, software tail and hardware head. A pending channel is picked
// round-robin and one DESC_WORDS-beat descriptor is read with a single AXI4
// INCR burst, then handed to the DMA engine tagged with its channel.
// Optional feature macro: DESC_FETCH_PROTO_CHECK_EN
//   defined   : desc_err flags non-OKAY rresp or a misplaced rlast
//   undefined : desc_err is 0 and rresp is ignored
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   cfg_ring_base/size    : per-channel ring base address and entry count
//   cfg_sw_tail           : per-channel software producer index
//   hw_head               : per-channel hardware consumer index
//   cfg_err               : sticky per-channel tail >= size flag
//   m_axi_ar* / m_axi_r*  : AXI4 read address / read data channels
//   desc_*                : descriptor output (valid/ready), channel, error
module desc_ring_fetcher_mc
  import desc_fetch_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DESC_WORDS = 4,
  parameter int IDX_W      = 8,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH*ADDR_W-1:0]     cfg_ring_base,
  input  logic [NUM_CH*(IDX_W+1)-1:0]  cfg_ring_size,
  input  logic [NUM_CH*IDX_W-1:0]      cfg_sw_tail,
  output logic [NUM_CH*IDX_W-1:0]      hw_head,
  output logic [NUM_CH-1:0]            cfg_err,
  output logic [ADDR_W-1:0]            m_axi_araddr,
  output logic [7:0]                   m_axi_arlen,
  output logic [2:0]                   m_axi_arsize,
  output logic [1:0]                   m_axi_arburst,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  input  logic [DATA_W-1:0]            m_axi_rdata,
  input  logic [1:0]                   m_axi_rresp,
  input  logic                         m_axi_rlast,
  input  logic                         m_axi_rvalid,
  output logic                         m_axi_rready,
  output logic                         desc_valid,
  input  logic                         desc_ready,
  output logic [DESC_WORDS*DATA_W-1:0] desc_data,
  output logic [CH_W-1:0]              desc_ch,
  output logic                         desc_err
);

  localparam int         BEAT_W     = $clog2(DESC_WORDS);
  localparam int         CNT_W      = BEAT_W + 1;
  localparam int         HW         = IDX_W + 1;
  localparam int         DESC_SHIFT = $clog2(DESC_WORDS * DATA_W / 8);
  localparam logic [2:0] ARSIZE     = calc_arsize(DATA_W);
  localparam logic [7:0] ARLEN      = 8'(DESC_WORDS - 1);

  fetch_state_t state;

  logic [ADDR_W-1:0] base_a [NUM_CH];
  logic [IDX_W:0]    size_a [NUM_CH];
  logic [IDX_W-1:0]  tail_a [NUM_CH];
  logic [IDX_W-1:0]  head_q [NUM_CH];
  logic [NUM_CH-1:0] err_q;
  logic [NUM_CH-1:0] pending;

  logic [NUM_CH-1:0] arb_gnt_unused;
  logic [CH_W-1:0]   arb_idx;
  logic              arb_any;

  logic [CH_W-1:0]   ch_q;
  logic [CNT_W-1:0]  beat_cnt;
  logic [ADDR_W-1:0] fetch_addr;
  logic [IDX_W:0]    head_inc;
  logic [IDX_W-1:0]  next_head;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign base_a[c] = cfg_ring_base[c*ADDR_W +: ADDR_W];
    assign size_a[c] = cfg_ring_size[c*(IDX_W+1) +: (IDX_W+1)];
    assign tail_a[c] = cfg_sw_tail[c*IDX_W +: IDX_W];
    assign hw_head[c*IDX_W +: IDX_W] = head_q[c];
  end

  assign cfg_err = err_q;

  // A bad tail blocks the channel in the same cycle it appears, before the
  // sticky flag has registered.
  always_comb begin
    pending = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pending[c] = (size_a[c] != '0) && !err_q[c] &&
                   ({1'b0, tail_a[c]} < size_a[c]) &&
                   (head_q[c] != tail_a[c]);
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!rst_n || size_a[c] == '0) begin
        err_q[c] <= 1'b0;
      end else if ({1'b0, tail_a[c]} >= size_a[c]) begin
        err_q[c] <= 1'b1;
      end
    end
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (pending),
    .accept  (state == ARB),
    .gnt     (arb_gnt_unused),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  assign fetch_addr = base_a[arb_idx] + (ADDR_W'(head_q[arb_idx]) << DESC_SHIFT);

  always_comb begin
    head_inc  = {1'b0, head_q[ch_q]} + HW'(1);
    next_head = (head_inc >= size_a[ch_q]) ? '0 : head_inc[IDX_W-1:0];
  end

`ifdef DESC_FETCH_PROTO_CHECK_EN
  logic err_acc;
  logic beat_err;
  // Late rlast shows up as a final-count beat without rlast; beats past the
  // count keep the flag set until rlast finally arrives.
  assign beat_err = (m_axi_rresp != RESP_OKAY) ||
                    ( m_axi_rlast && beat_cnt != CNT_W'(DESC_WORDS - 1)) ||
                    (!m_axi_rlast && beat_cnt >= CNT_W'(DESC_WORDS - 1));
`else
  logic rresp_unused;
  assign rresp_unused = ^m_axi_rresp;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      ch_q          <= '0;
      beat_cnt      <= '0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arsize  <= '0;
      m_axi_arburst <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      desc_valid    <= 1'b0;
      desc_data     <= '0;
      desc_ch       <= '0;
      desc_err      <= 1'b0;
`ifdef DESC_FETCH_PROTO_CHECK_EN
      err_acc       <= 1'b0;
`endif
      for (int c = 0; c < NUM_CH; c++) head_q[c] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) state <= ARB;
        end
        ARB: begin
          // Address and channel are frozen here; later config edits only
          // influence the next arbitration.
          if (arb_any) begin
            ch_q          <= arb_idx;
            m_axi_araddr  <= fetch_addr;
            m_axi_arlen   <= ARLEN;
            m_axi_arsize  <= ARSIZE;
            m_axi_arburst <= BURST_INCR;
            m_axi_arvalid <= 1'b1;
            state         <= AR;
          end else begin
            state <= IDLE;
          end
        end
        AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            beat_cnt      <= '0;
`ifdef DESC_FETCH_PROTO_CHECK_EN
            err_acc       <= 1'b0;
`endif
            state         <= RD;
          end
        end
        RD: begin
          if (m_axi_rvalid) begin
            // Beats past DESC_WORDS are accepted but not stored.
            if (beat_cnt != CNT_W'(DESC_WORDS)) begin
              desc_data[beat_cnt[BEAT_W-1:0]*DATA_W +: DATA_W] <= m_axi_rdata;
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
`ifdef DESC_FETCH_PROTO_CHECK_EN
            err_acc <= err_acc | beat_err;
`endif
            if (m_axi_rlast) begin
              m_axi_rready <= 1'b0;
              desc_valid   <= 1'b1;
              desc_ch      <= ch_q;
`ifdef DESC_FETCH_PROTO_CHECK_EN
              desc_err     <= err_acc | beat_err;
`endif
              state        <= OUT;
            end
          end
        end
        OUT: begin
          if (desc_ready) begin
            desc_valid   <= 1'b0;
            head_q[ch_q] <= next_head;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_desc_ring_fetcher_mc.sv
// tb_desc_ring_fetcher_mc
// Scoreboard bench for desc_ring_fetcher_mc: expected descriptors are queued
// when ring tails are advanced and compared when the DUT hands them out.
// A randomized AXI read slave returns address-derived data.
module tb_desc_ring_fetcher_mc;

  localparam int NUM_CH     = 2;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int DESC_WORDS = 4;
  localparam int IDX_W      = 8;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic [NUM_CH*ADDR_W-1:0]     cfg_ring_base;
  logic [NUM_CH*(IDX_W+1)-1:0]  cfg_ring_size;
  logic [NUM_CH*IDX_W-1:0]      cfg_sw_tail;
  logic [NUM_CH*IDX_W-1:0]      hw_head;
  logic [NUM_CH-1:0]            cfg_err;
  logic [ADDR_W-1:0]            m_axi_araddr;
  logic [7:0]                   m_axi_arlen;
  logic [2:0]                   m_axi_arsize;
  logic [1:0]                   m_axi_arburst;
  logic                         m_axi_arvalid;
  logic                         m_axi_arready;
  logic [DATA_W-1:0]            m_axi_rdata;
  logic [1:0]                   m_axi_rresp;
  logic                         m_axi_rlast;
  logic                         m_axi_rvalid;
  logic                         m_axi_rready;
  logic                         desc_valid;
  logic                         desc_ready;
  logic [DESC_WORDS*DATA_W-1:0] desc_data;
  logic [0:0]                   desc_ch;
  logic                         desc_err;

  logic [ADDR_W-1:0] base_m [NUM_CH];
  logic [IDX_W:0]    size_m [NUM_CH];
  logic [IDX_W-1:0]  tail_m [NUM_CH];

  assign cfg_ring_base = {base_m[1], base_m[0]};
  assign cfg_ring_size = {size_m[1], size_m[0]};
  assign cfg_sw_tail   = {tail_m[1], tail_m[0]};

  always #5 clk = ~clk;

  desc_ring_fetcher_mc #(
    .NUM_CH     (NUM_CH),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .DESC_WORDS (DESC_WORDS),
    .IDX_W      (IDX_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_ring_base (cfg_ring_base),
    .cfg_ring_size (cfg_ring_size),
    .cfg_sw_tail   (cfg_sw_tail),
    .hw_head       (hw_head),
    .cfg_err       (cfg_err),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .desc_valid    (desc_valid),
    .desc_ready    (desc_ready),
    .desc_data     (desc_data),
    .desc_ch       (desc_ch),
    .desc_err      (desc_err)
  );

  typedef struct {
    int          ch;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          exp_head [NUM_CH];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          err_beat = -1;
  int          ar_count = 0;
  logic [31:0] last_ar_addr = '0;
  logic        hold = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [127:0] exp_data(input logic [31:0] a);
    logic [127:0] d;
    d = '0;
    for (int b = 0; b < DESC_WORDS; b++) d[b*32 +: 32] = mem_word(a + 32'(b * 4));
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue the next fetch expected on channel c and advance the head model.
  task automatic push_fetch(input int c, input logic err);
    exp_t x;
    x.ch   = c;
    x.addr = base_m[c] + 32'(exp_head[c] * 16);
    x.err  = err;
    exp_q.push_back(x);
    exp_head[c] = (exp_head[c] + 1 >= int'(size_m[c])) ? 0 : exp_head[c] + 1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      step();
      n++;
    end
    check("drain_queue", 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    tail_m[0] = '0;
    tail_m[1] = '0;
    step();
    step();
    exp_q.delete();
    exp_head[0] = 0;
    exp_head[1] = 0;
    rst_n = 1'b1;
    step();
  endtask

  // AXI read slave with random arready and rvalid gaps.
  initial begin : mem_slave
    int          st;
    int          beat;
    logic [31:0] addr;
    logic        hs_ar, hs_r, in_rst;
    logic [31:0] araddr_s;
    logic [7:0]  len_s;
    logic [2:0]  size_s;
    logic [1:0]  burst_s;
    st = 0; beat = 0; addr = '0;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rlast   = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    forever begin
      @(posedge clk);
      hs_ar    = m_axi_arvalid && m_axi_arready;
      hs_r     = m_axi_rvalid && m_axi_rready;
      in_rst   = !rst_n;
      araddr_s = m_axi_araddr;
      len_s    = m_axi_arlen;
      size_s   = m_axi_arsize;
      burst_s  = m_axi_arburst;
      #1;
      if (in_rst) begin
        st = 0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
      end else if (st == 0) begin
        if (hs_ar) begin
          ar_count++;
          check("arlen", len_s, 3);
          check("arsize", size_s, 2);
          check("arburst", burst_s, 1);
          last_ar_addr  = araddr_s;
          addr          = araddr_s;
          st            = 1;
          beat          = 0;
          m_axi_arready = 1'b0;
        end else begin
          m_axi_arready = ($urandom_range(0, 1) == 1);
        end
      end else begin
        if (hs_r) beat++;
        if (beat == DESC_WORDS) begin
          st = 0;
          m_axi_rvalid = 1'b0;
          m_axi_rlast  = 1'b0;
        end else if (hs_r || !m_axi_rvalid) begin
          m_axi_rvalid = ($urandom_range(0, 3) != 0);
          m_axi_rdata  = mem_word(addr + 32'(beat * 4));
          m_axi_rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
          m_axi_rlast  = (beat == DESC_WORDS - 1);
        end
      end
    end
  end

  // Descriptor sink: pops the scoreboard on each handshake.
  initial begin : desc_sink
    logic         hs;
    logic [127:0] d;
    logic [0:0]   ch;
    logic         e;
    exp_t         x;
    desc_ready = 1'b0;
    forever begin
      @(posedge clk);
      hs = desc_valid && desc_ready && rst_n;
      d  = desc_data;
      ch = desc_ch;
      e  = desc_err;
      #1;
      if (hs) begin
        check("desc_expected_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          x = exp_q.pop_front();
          check("desc_ch", ch, x.ch);
          check("desc_data", d, exp_data(x.addr));
          check("desc_err", e, x.err);
          check("araddr", last_ar_addr, x.addr);
        end
      end
      desc_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [127:0] snap_d;
    logic [0:0]   snap_ch;
    logic         stable, ar_seen, exp_err;
    int           n, ar_before;

    rst_n     = 1'b0;
    base_m[0] = 32'h0000_0000;
    base_m[1] = 32'h0000_1000;
    size_m[0] = '0;
    size_m[1] = '0;
    tail_m[0] = '0;
    tail_m[1] = '0;
    exp_head[0] = 0;
    exp_head[1] = 0;
    step();
    step();
    check("rst_hw_head", hw_head, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_arvalid", m_axi_arvalid, 0);
    check("rst_araddr", m_axi_araddr, 0);
    check("rst_rready", m_axi_rready, 0);
    check("rst_desc_valid", desc_valid, 0);
    check("rst_desc_data", desc_data, 0);
    check("rst_desc_ch", desc_ch, 0);
    check("rst_desc_err", desc_err, 0);
    rst_n = 1'b1;
    size_m[0] = 9'd256;
    size_m[1] = 9'd256;
    step();

    // Single fetch on ch0 with latency check.
    push_fetch(0, 1'b0);
    tail_m[0] = 8'd1;
    step();
    check("lat_arvalid_n1", m_axi_arvalid, 0);
    step();
    check("lat_arvalid_n2", m_axi_arvalid, 1);
    check("lat_araddr", m_axi_araddr, 0);
    wait_drain();
    check("t1_head0", hw_head[7:0], 1);

    // Two channels pending together: strict rotation 0,1,0,1.
    do_reset();
    push_fetch(0, 1'b0);
    push_fetch(1, 1'b0);
    push_fetch(0, 1'b0);
    push_fetch(1, 1'b0);
    tail_m[0] = 8'd2;
    tail_m[1] = 8'd2;
    wait_drain();
    check("t2_head0", hw_head[7:0], 2);
    check("t2_head1", hw_head[15:8], 2);

    // Ring of 4 entries wrapping from entry 3 to entry 0.
    do_reset();
    size_m[0] = 9'd4;
    step();
    push_fetch(0, 1'b0);
    push_fetch(0, 1'b0);
    push_fetch(0, 1'b0);
    tail_m[0] = 8'd3;
    wait_drain();
    check("t3_head_mid", hw_head[7:0], 3);
    push_fetch(0, 1'b0);
    push_fetch(0, 1'b0);
    tail_m[0] = 8'd1;
    wait_drain();
    check("t3_head_wrap", hw_head[7:0], 1);

    // Back-pressure: descriptor held stable, no new burst.
    hold = 1'b1;
    step();
    push_fetch(0, 1'b0);
    push_fetch(0, 1'b0);
    tail_m[0] = 8'd3;
    n = 0;
    while (!desc_valid && n < 300) begin
      step();
      n++;
    end
    check("hold_valid_seen", desc_valid, 1);
    snap_d  = desc_data;
    snap_ch = desc_ch;
    stable  = 1'b1;
    ar_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (desc_data !== snap_d || desc_ch !== snap_ch || !desc_valid) stable = 1'b0;
      if (m_axi_arvalid) ar_seen = 1'b1;
    end
    check("hold_stable", stable, 1);
    check("hold_no_arvalid", ar_seen, 0);
    check("hold_head", hw_head[7:0], 1);
    hold = 1'b0;
    wait_drain();
    check("hold_head_after", hw_head[7:0], 3);

    // Error response on beat 2, then an out-of-range tail.
    do_reset();
`ifdef DESC_FETCH_PROTO_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    err_beat = 2;
    push_fetch(0, exp_err);
    tail_m[0] = 8'd1;
    wait_drain();
    err_beat = -1;
    check("slverr_head", hw_head[7:0], 1);
    ar_before = ar_count;
    size_m[1] = 9'd4;
    tail_m[1] = 8'd5;
    repeat (20) step();
    check("cfg_err_set", cfg_err, 2'b10);
    check("cfg_err_no_ar", ar_count, ar_before);
    check("cfg_err_head1", hw_head[15:8], 0);
    size_m[1] = '0;
    step();
    step();
    check("cfg_err_clear", cfg_err, 0);
    tail_m[1] = '0;
    size_m[1] = 9'd256;

    // Reset in the middle of a burst.
    do_reset();
    tail_m[0] = 8'd1;
    n = 0;
    while (!m_axi_rready && n < 300) begin
      step();
      n++;
    end
    check("midrst_rready_seen", m_axi_rready, 1);
    rst_n     = 1'b0;
    tail_m[0] = '0;
    step();
    check("midrst_arvalid", m_axi_arvalid, 0);
    check("midrst_rready", m_axi_rready, 0);
    check("midrst_hw_head", hw_head, 0);
    check("midrst_desc_valid", desc_valid, 0);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (5) step();
    check("post_rst_idle", m_axi_arvalid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/desc_ring_fetcher_mc.md
# desc_ring_fetcher_mc

Multi-channel descriptor ring fetcher for the crypto DMA subsystem, successor to the single-ring fetcher. Keeps NUM_CH independent descriptor rings in memory, each with its own base, size, software tail and hardware head. Picks a pending channel round-robin and reads one DESC_WORDS-beat descriptor per AXI4 INCR burst. Presents the assembled descriptor, tagged with its channel, to the DMA engine over a valid/ready port.

## Interface
- NUM_CH, 2: number of rings, 1..8
- ADDR_W, 32: AXI address width
- DATA_W, 32: AXI data width, 32 or 64
- DESC_WORDS, 4: beats per descriptor, power of two, 2..16
- IDX_W, 8: ring index width; ring holds up to 2^IDX_W entries
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- cfg_ring_base  in  NUM_CH*ADDR_W  per-channel ring base, aligned to DESC_WORDS*DATA_W/8 bytes
- cfg_ring_size  in  NUM_CH*(IDX_W+1)  entries per ring; 0 disables the channel
- cfg_sw_tail  in  NUM_CH*IDX_W  software producer index
- hw_head  out  NUM_CH*IDX_W  consumer index per channel
- cfg_err  out  NUM_CH  sticky per channel: tail >= size; cleared by reset or by size written to 0
- m_axi_araddr  out  ADDR_W; m_axi_arlen  out  8; m_axi_arsize  out  3; m_axi_arburst  out  2; m_axi_arvalid  out  1; m_axi_arready  in  1
- m_axi_rdata  in  DATA_W; m_axi_rresp  in  2; m_axi_rlast  in  1; m_axi_rvalid  in  1; m_axi_rready  out  1
- desc_valid  out  1; desc_ready  in  1; desc_data  out  DESC_WORDS*DATA_W, beat 0 in the LSBs; desc_ch  out  $clog2(NUM_CH) (minimum 1); desc_err  out  1

## Operation
- Channel c is pending when size != 0, cfg_err[c] = 0 and hw_head[c] != cfg_sw_tail[c].
- Channel c with cfg_sw_tail >= size: cfg_err[c] is set and the channel is never pending.
- FSM states:
  - IDLE: move to ARB when any channel is pending.
  - ARB: latch the round-robin winner; the pointer starts after the last granted channel, and channel 0 comes first after reset.
  - AR: drive the address, arlen = DESC_WORDS-1, arsize = log2(DATA_W/8), arburst = 2'b01 (INCR).
  - RD: rready = 1; store beats by count.
  - OUT: desc_valid = 1 until desc_ready.
- Address = base + head*DESC_WORDS*(DATA_W/8), computed in ADDR_W bits with natural wrap.
- On the OUT handshake, hw_head[ch] increments, wrapping to 0 after size-1. Then go to IDLE.
- Config changes during a fetch affect only later arbitration. The latched address and channel stay fixed.
- No second burst is issued while a descriptor is held; only one burst is ever outstanding.

## Timing
- Reset values: all outputs 0, including hw_head, cfg_err, arvalid, rready, desc_valid, desc_data, desc_ch and desc_err. Round-robin pointer = 0, state = IDLE.
- Latency with the pending condition true at edge N: arvalid high after edge N+2, when IDLE→ARB→AR.
- desc_valid rises the cycle after the rlast beat is accepted.
- With zero-wait memory, the next arvalid follows 2 cycles after the desc handshake.
- arvalid and araddr stay stable until arready. desc_data and desc_ch stay stable while desc_valid && !desc_ready.
- When several channels are pending together, the grant follows strict rotation, with no starvation.
- Reset asserted mid-burst returns to IDLE next edge and drops arvalid and rready. The memory side must be reset together with this block.

## Configuration
- DESC_FETCH_PROTO_CHECK_EN defined:
  - desc_err = 1 if any beat has rresp != OKAY, or rlast arrives early or late versus DESC_WORDS.
  - An early rlast ends the burst. Beats after the count are accepted and dropped until rlast.
  - hw_head still advances.
- Undefined: desc_err is tied 0, rresp is ignored, and the burst ends on rlast only.

## Structure
- Package desc_fetch_pkg holds:
  - the state enum (IDLE, ARB, AR, RD, OUT)
  - AXI constants: BURST_INCR, RESP_OKAY
  - the helper function computing arsize from DATA_W
- Sub-module rr_arbiter (NUM_CH requests in; one-hot grant and index out; pointer advances only on an accepted grant).

## Test plan
- Ring ch0 base 0x0, size 256; tail 0→1; DESC_WORDS=4 → one AR at 0x0, arlen=3, arsize=2; desc_data = {mem[3],mem[2],mem[1],mem[0]}; hw_head[0]=1.
- ch0 and ch1 both with tail = head+2 → grants in order 0,1,0,1; ch1 addresses at base1+0x0 then base1+0x10.
- size 4, head 3, tail 1 → fetches at entry 3 then entry 0; hw_head ends at 1.
- desc_ready held low 20 cycles → desc_data stable, no new arvalid; release → head increments once.
- rresp = SLVERR on beat 2 with the check macro on → desc_err=1, head advances. Tail 5 with size 4 → cfg_err=1, no AR.
- rst_n low mid-burst → arvalid=0, rready=0, hw_head=0 on the next edge.
